// File: rtl/fifo_cdc_pkg.sv
// Shared constants and helpers for the CDC FIFO pointer controllers.
// Both clock-domain instances use this package.
package fifo_cdc_pkg;

  localparam int MODE_WR         = 0;
  localparam int MODE_RD         = 1;
  localparam int SYNC_STAGES_DEF = 2;

  // The extra MSB is the wrap (phase) bit that tells full apart from empty.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/bin_to_gray.sv
// Binary to reflected-Gray converter, purely combinational.
module bin_to_gray #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray_to_bin.sv
// Gray to binary decoder: each binary bit is the XOR of all Gray bits
// from the MSB down to that position.
module gray_to_bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_ptr_ctrl.sv
// One side of a dual-clock FIFO: local binary/Gray pointer, remote pointer
// synchroniser, occupancy level and a full (write) or empty (read) flag.
module gray_ptr_ctrl
  import fifo_cdc_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int MODE        = MODE_WR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc,
  input  logic [ADDR_WIDTH:0]   remote_gray,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH:0]   ptr_bin,
  output logic [ADDR_WIDTH:0]   ptr_gray,
  output logic [ADDR_WIDTH:0]   remote_bin,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  flag,
  output logic                  err
);

  localparam int   PW       = ptr_width(ADDR_WIDTH);
  localparam logic FLAG_RST = (MODE == MODE_RD) ? 1'b1 : 1'b0;

  logic [PW-1:0] ptr_bin_q, ptr_bin_d;
  logic [PW-1:0] ptr_gray_q, ptr_gray_d;
  logic [PW-1:0] level_q, level_d;
  logic          flag_q, flag_d;
  logic          err_q, err_d;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] rsync;
  logic          acc;

  assign acc       = inc & ~flag_q;
  assign ptr_bin_d = acc ? ptr_bin_q + PW'(1) : ptr_bin_q;
  assign err_d     = inc & flag_q;
  assign rsync     = sync_q[SYNC_STAGES-1];

  bin_to_gray #(.WIDTH(PW)) u_b2g (
    .bin_i  (ptr_bin_d),
    .gray_o (ptr_gray_d)
  );

  gray_to_bin #(.WIDTH(PW)) u_g2b (
    .gray_i (rsync),
    .bin_o  (remote_bin)
  );

  // Flag and level look at the next-state pointer so the flag rises on the
  // same edge the pointer lands on full/empty; the remote side is always stale.
  if (MODE == MODE_WR) begin : g_wr
    logic [PW-1:0] full_cmp;
    if (PW == 2) begin : g_pw2
      assign full_cmp = ~rsync;
    end else begin : g_pwn
      assign full_cmp = {~rsync[PW-1:PW-2], rsync[PW-3:0]};
    end
    assign flag_d  = (ptr_gray_d == full_cmp);
    assign level_d = ptr_bin_d - remote_bin;
  end else begin : g_rd
    assign flag_d  = (ptr_gray_d == rsync);
    assign level_d = remote_bin - ptr_bin_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= remote_gray;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_bin_q  <= '0;
      ptr_gray_q <= '0;
      level_q    <= '0;
      flag_q     <= FLAG_RST;
      err_q      <= 1'b0;
    end else begin
      ptr_bin_q  <= ptr_bin_d;
      ptr_gray_q <= ptr_gray_d;
      level_q    <= level_d;
      flag_q     <= flag_d;
      err_q      <= err_d;
    end
  end

  assign addr     = ptr_bin_q[ADDR_WIDTH-1:0];
  assign ptr_bin  = ptr_bin_q;
  assign ptr_gray = ptr_gray_q;
  assign level    = level_q;
  assign flag     = flag_q;
  assign err      = err_q;

endmodule

// File: tb/tb_gray_ptr_ctrl.sv
// Directed and model-based checks of gray_ptr_ctrl, one write-side and one
// read-side instance with ADDR_WIDTH=2, SYNC_STAGES=2.
module tb_gray_ptr_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       incW = 1'b0, incR = 1'b0;
  logic [2:0] remoteW = '0, remoteR = '0;
  logic [1:0] addrW, addrR;
  logic [2:0] binW, grayW, rbinW, levelW;
  logic [2:0] binR, grayR, rbinR, levelR;
  logic       flagW, errW, flagR, errR;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gray_ptr_ctrl #(.ADDR_WIDTH(2), .SYNC_STAGES(2), .MODE(0)) dutW (
    .clk(clk), .rst_n(rst_n), .inc(incW), .remote_gray(remoteW),
    .addr(addrW), .ptr_bin(binW), .ptr_gray(grayW), .remote_bin(rbinW),
    .level(levelW), .flag(flagW), .err(errW)
  );

  gray_ptr_ctrl #(.ADDR_WIDTH(2), .SYNC_STAGES(2), .MODE(1)) dutR (
    .clk(clk), .rst_n(rst_n), .inc(incR), .remote_gray(remoteR),
    .addr(addrR), .ptr_bin(binR), .ptr_gray(grayR), .remote_bin(rbinR),
    .level(levelR), .flag(flagR), .err(errR)
  );

  // Reference model: sequential Gray decode, full as MSB-pair-inverted match.
  function automatic logic [2:0] g2b(input logic [2:0] g);
    logic [2:0] b;
    b[2] = g[2];
    for (int i = 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [2:0] mwBin, mwS0, mwS1, mwLevel, mwNext;
  logic       mwFlag, mwErr;
  logic [2:0] mrBin, mrS0, mrS1, mrLevel, mrNext;
  logic       mrFlag, mrErr;

  assign mwNext = mwBin + {2'b00, incW & ~mwFlag};
  assign mrNext = mrBin + {2'b00, incR & ~mrFlag};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mwBin <= '0; mwS0 <= '0; mwS1 <= '0; mwLevel <= '0; mwFlag <= 1'b0; mwErr <= 1'b0;
    end else begin
      mwS0    <= remoteW;
      mwS1    <= mwS0;
      mwBin   <= mwNext;
      mwLevel <= mwNext - g2b(mwS1);
      mwFlag  <= ((mwNext ^ (mwNext >> 1)) == (mwS1 ^ 3'b110));
      mwErr   <= incW & mwFlag;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mrBin <= '0; mrS0 <= '0; mrS1 <= '0; mrLevel <= '0; mrFlag <= 1'b1; mrErr <= 1'b0;
    end else begin
      mrS0    <= remoteR;
      mrS1    <= mrS0;
      mrBin   <= mrNext;
      mrLevel <= g2b(mrS1) - mrNext;
      mrFlag  <= ((mrNext ^ (mrNext >> 1)) == mrS1);
      mrErr   <= incR & mrFlag;
    end
  end

  typedef struct {
    logic       inc;
    logic [2:0] expBin;
    logic [2:0] expGray;
    logic [2:0] expLevel;
    logic       expFlag;
    logic       expErr;
  } vec_t;

  vec_t vecW [6];
  vec_t vecR [6];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs at the falling edge, then advance to the next falling edge.
  task automatic applyStimulus(input logic iw, input logic ir);
    incW = iw;
    incR = ir;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [2:0] eb, prevG, h1, h2, rpW, wpR;

  initial begin
    vecW[0] = '{1'b1, 3'd1, 3'b001, 3'd1, 1'b0, 1'b0};
    vecW[1] = '{1'b1, 3'd2, 3'b011, 3'd2, 1'b0, 1'b0};
    vecW[2] = '{1'b1, 3'd3, 3'b010, 3'd3, 1'b0, 1'b0};
    vecW[3] = '{1'b1, 3'd4, 3'b110, 3'd4, 1'b1, 1'b0};
    vecW[4] = '{1'b1, 3'd4, 3'b110, 3'd4, 1'b1, 1'b1};
    vecW[5] = '{1'b0, 3'd4, 3'b110, 3'd4, 1'b1, 1'b0};
    vecR[0] = '{1'b1, 3'd1, 3'b001, 3'd3, 1'b0, 1'b0};
    vecR[1] = '{1'b1, 3'd2, 3'b011, 3'd2, 1'b0, 1'b0};
    vecR[2] = '{1'b1, 3'd3, 3'b010, 3'd1, 1'b0, 1'b0};
    vecR[3] = '{1'b1, 3'd4, 3'b110, 3'd0, 1'b1, 1'b0};
    vecR[4] = '{1'b1, 3'd4, 3'b110, 3'd0, 1'b1, 1'b1};
    vecR[5] = '{1'b0, 3'd4, 3'b110, 3'd0, 1'b1, 1'b0};

    #12;
    checkOutput("rst_flagW", {31'd0, flagW}, 32'd0);
    checkOutput("rst_flagR", {31'd0, flagR}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill the write side against a parked read pointer
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecW[i].inc, 1'b0);
      checkOutput($sformatf("wr_bin%0d", i),   {29'd0, binW},   {29'd0, vecW[i].expBin});
      checkOutput($sformatf("wr_gray%0d", i),  {29'd0, grayW},  {29'd0, vecW[i].expGray});
      checkOutput($sformatf("wr_level%0d", i), {29'd0, levelW}, {29'd0, vecW[i].expLevel});
      checkOutput($sformatf("wr_flag%0d", i),  {31'd0, flagW},  {31'd0, vecW[i].expFlag});
      checkOutput($sformatf("wr_err%0d", i),   {31'd0, errW},   {31'd0, vecW[i].expErr});
    end
    checkOutput("wr_addr_wrap", {30'd0, addrW}, 32'd0);

    // Remote read pointer advances by one; flag drops three edges later
    remoteW = 3'b001;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("wr_stale_flag", {31'd0, flagW}, 32'd1);
    checkOutput("wr_rbin", {29'd0, rbinW}, 32'd1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("wr_free_flag", {31'd0, flagW}, 32'd0);
    checkOutput("wr_free_level", {29'd0, levelW}, 32'd3);
    applyStimulus(1'b1, 1'b0);
    checkOutput("wr_refill_bin", {29'd0, binW}, 32'd5);
    checkOutput("wr_refill_flag", {31'd0, flagW}, 32'd1);
    checkOutput("wr_refill_level", {29'd0, levelW}, 32'd4);
    applyStimulus(1'b0, 1'b0);

    // Read side sees a full remote write pointer
    remoteR = 3'b110;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("rd_rbin", {29'd0, rbinR}, 32'd4);
    checkOutput("rd_stale_flag", {31'd0, flagR}, 32'd1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("rd_avail_flag", {31'd0, flagR}, 32'd0);
    checkOutput("rd_avail_level", {29'd0, levelR}, 32'd4);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, vecR[i].inc);
      checkOutput($sformatf("rd_bin%0d", i),   {29'd0, binR},   {29'd0, vecR[i].expBin});
      checkOutput($sformatf("rd_gray%0d", i),  {29'd0, grayR},  {29'd0, vecR[i].expGray});
      checkOutput($sformatf("rd_level%0d", i), {29'd0, levelR}, {29'd0, vecR[i].expLevel});
      checkOutput($sformatf("rd_flag%0d", i),  {31'd0, flagR},  {31'd0, vecR[i].expFlag});
      checkOutput($sformatf("rd_err%0d", i),   {31'd0, errR},   {31'd0, vecR[i].expErr});
    end

    // Asynchronous reset in the middle of a cycle
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_binW",   {29'd0, binW},   32'd0);
    checkOutput("arst_grayW",  {29'd0, grayW},  32'd0);
    checkOutput("arst_levelW", {29'd0, levelW}, 32'd0);
    checkOutput("arst_flagW",  {31'd0, flagW},  32'd0);
    checkOutput("arst_rbinW",  {29'd0, rbinW},  32'd0);
    checkOutput("arst_binR",   {29'd0, binR},   32'd0);
    checkOutput("arst_levelR", {29'd0, levelR}, 32'd0);
    checkOutput("arst_flagR",  {31'd0, flagR},  32'd1);
    checkOutput("arst_errR",   {31'd0, errR},   32'd0);
    remoteW = '0;
    remoteR = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Wrap: remote tracks the local Gray pointer two cycles late
    eb = '0; prevG = '0; h1 = '0; h2 = '0;
    for (int c = 0; c < 40; c++) begin
      remoteW = h2;
      applyStimulus((c % 2) == 0, 1'b0);
      if ((c % 2) == 0) eb = eb + 3'd1;
      checkOutput("wrap_bin", {29'd0, binW}, {29'd0, eb});
      checkOutput("wrap_gray", {29'd0, grayW}, {29'd0, eb ^ (eb >> 1)});
      if ((c % 2) == 0)
        checkOutput("wrap_hamming", $countones(grayW ^ prevG), 32'd1);
      checkOutput("wrap_noflag", {31'd0, flagW}, 32'd0);
      prevG = grayW;
      h2 = h1;
      h1 = eb ^ (eb >> 1);
    end
    checkOutput("wrap_final", {29'd0, binW}, 32'd4);

    // Random traffic on both sides against the reference model
    incW = 1'b0; incR = 1'b0;
    rst_n = 1'b0;
    remoteW = '0; remoteR = '0;
    rpW = '0; wpR = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 2) == 0 && rpW != mwBin) rpW = rpW + 3'd1;
      if ($urandom_range(0, 2) == 0 && (wpR - mrBin) != 3'd4) wpR = wpR + 3'd1;
      remoteW = rpW ^ (rpW >> 1);
      remoteR = wpR ^ (wpR >> 1);
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checkOutput("rand_wr", {24'd0, flagW, levelW, errW, binW}, {24'd0, mwFlag, mwLevel, mwErr, mwBin});
      checkOutput("rand_rd", {24'd0, flagR, levelR, errR, binR}, {24'd0, mrFlag, mrLevel, mrErr, mrBin});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
